alu_ctrl: RTL

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_pkg.sv | 71 +++++++
 rtl/alu.sv | 66 ++++++
 rtl/alu_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU controller: op codes, ALU Func codes,
// controller states and the multiply iteration count.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_NOR   = 4'd4,
        OP_NAND  = 4'd5,
        OP_SLTU  = 4'd6,
        OP_SLT   = 4'd7,
        OP_XOR   = 4'd8,
        OP_PASSA = 4'd9,
        OP_PASSB = 4'd10,
        OP_BEQ   = 4'd11,
        OP_BNE   = 4'd12,
        OP_MULU  = 4'd13
    } op_e;

    // Codes at or above this value are undefined
    localparam int unsigned OP_NUM = 14;

    localparam logic [5:0] FUNC_ADD   = 6'b000010;
    localparam logic [5:0] FUNC_SUB   = 6'b000100;
    localparam logic [5:0] FUNC_AND   = 6'b001000;
    localparam logic [5:0] FUNC_OR    = 6'b010000;
    localparam logic [5:0] FUNC_NOR   = 6'b100000;
    localparam logic [5:0] FUNC_NAND  = 6'b000011;
    localparam logic [5:0] FUNC_SLTU  = 6'b000101;
    localparam logic [5:0] FUNC_SLT   = 6'b001001;
    localparam logic [5:0] FUNC_XOR   = 6'b010001;
    localparam logic [5:0] FUNC_PASSA = 6'b100101;
    localparam logic [5:0] FUNC_PASSB = 6'b101001;
    localparam logic [5:0] FUNC_BEQ   = 6'b100011;
    localparam logic [5:0] FUNC_BNE   = 6'b100001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam int unsigned MUL_ITERS = 32;
    localparam int unsigned CNT_W     = 5;

    // MULU and anything unmapped fall back to ADD so the ALU never sees an illegal Func
    function automatic logic [5:0] op_to_func(input op_e op);
        logic [5:0] func;
        case (op)
            OP_ADD:   func = FUNC_ADD;
            OP_SUB:   func = FUNC_SUB;
            OP_AND:   func = FUNC_AND;
            OP_OR:    func = FUNC_OR;
            OP_NOR:   func = FUNC_NOR;
            OP_NAND:  func = FUNC_NAND;
            OP_SLTU:  func = FUNC_SLTU;
            OP_SLT:   func = FUNC_SLT;
            OP_XOR:   func = FUNC_XOR;
            OP_PASSA: func = FUNC_PASSA;
            OP_PASSB: func = FUNC_PASSB;
            OP_BEQ:   func = FUNC_BEQ;
            OP_BNE:   func = FUNC_BNE;
            default:  func = FUNC_ADD;
        endcase
        return func;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU with a single shared add/subtract path.
// OV is carry-out for ADD/SUB, branch-taken for BEQ/BNE, otherwise 0.
module alu
    import alu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [5:0]  func_i,
    output logic [31:0] o_o,
    output logic        ov_o
);

    logic        sub;
    logic [31:0] b_op;
    logic [32:0] sum;
    logic        lt_u;
    logic        lt_s;
    logic        eq;

    always_comb begin
        sub  = (func_i != FUNC_ADD);
        b_op = sub ? ~b_i : b_i;
        sum  = {1'b0, a_i} + {1'b0, b_op} + {32'd0, sub};
        lt_u = ~sum[32];
        // On differing signs the negative operand is the smaller one
        lt_s = (a_i[31] ^ b_i[31]) ? a_i[31] : sum[31];
        eq   = (sum[31:0] == 32'd0);
    end

    always_comb begin
        o_o  = 32'd0;
        ov_o = 1'b0;
        case (func_i)
            FUNC_ADD: begin
                o_o  = sum[31:0];
                ov_o = sum[32];
            end
            FUNC_SUB: begin
                o_o  = sum[31:0];
                ov_o = sum[32];
            end
            FUNC_AND:   o_o = a_i & b_i;
            FUNC_OR:    o_o = a_i | b_i;
            FUNC_NOR:   o_o = ~(a_i | b_i);
            FUNC_NAND:  o_o = ~(a_i & b_i);
            FUNC_SLTU:  o_o = {31'd0, lt_u};
            FUNC_SLT:   o_o = {31'd0, lt_s};
            FUNC_XOR:   o_o = a_i ^ b_i;
            FUNC_PASSA: o_o = a_i;
            FUNC_PASSB: o_o = b_i;
            FUNC_BEQ: begin
                o_o  = sum[31:0];
                ov_o = eq;
            end
            FUNC_BNE: begin
                o_o  = sum[31:0];
                ov_o = ~eq;
            end
            default: begin
                o_o  = 32'd0;
                ov_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl.sv
// Request/response controller around a shared ALU; single-step ops plus a
// 32-iteration shift-add unsigned multiply that reuses the ALU adder.
//
//  state | meaning
//  IDLE  | ready for a request, ALU parked on ADD
//  EXEC  | one-cycle single-step op, result registered on exit
//  MUL   | shift-add iteration, down-counter terminates at zero
//  RESP  | result held until rsp_ready
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [OPW-1:0] req_op,
    input  logic [31:0]    req_a,
    input  logic [31:0]    req_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [31:0]    rsp_data,
    output logic           rsp_ov
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      mcand_q, mcand_d;
    logic [31:0]      mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             rsp_ov_q, rsp_ov_d;

    logic             req_op_defined;
    op_e              req_op_e;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [5:0]       alu_func;
    logic [31:0]      alu_o;
    logic             alu_ov;
    logic [31:0]      mul_acc_next;

    // Upper code bits beyond the enum width make the op undefined
    assign req_op_defined = (req_op < OPW'(OP_NUM));
    assign req_op_e       = op_e'(req_op[3:0]);
    assign mul_acc_next   = mplier_q[0] ? alu_o : acc_q;

    alu u_alu (
        .a_i    (alu_a),
        .b_i    (alu_b),
        .func_i (alu_func),
        .o_o    (alu_o),
        .ov_o   (alu_ov)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_ov_d   = rsp_ov_q;
        alu_a      = acc_q;
        alu_b      = mcand_q;
        alu_func   = FUNC_ADD;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d = req_op_e;
                    a_d  = req_a;
                    b_d  = req_b;
                    if (!req_op_defined) begin
                        rsp_data_d = 32'd0;
                        rsp_ov_d   = 1'b1;
                        state_d    = ST_RESP;
                    end else if (req_op_e == OP_MULU) begin
                        acc_d    = 32'd0;
                        mcand_d  = req_a;
                        mplier_d = req_b;
                        cnt_d    = CNT_W'(MUL_ITERS - 1);
                        state_d  = ST_MUL;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end

            ST_EXEC: begin
                alu_a      = a_q;
                alu_b      = b_q;
                alu_func   = op_to_func(op_q);
                rsp_data_d = alu_o;
                rsp_ov_d   = alu_ov;
                state_d    = ST_RESP;
            end

            ST_MUL: begin
                acc_d    = mul_acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == '0) begin
                    rsp_data_d = mul_acc_next;
                    rsp_ov_d   = 1'b0;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_ADD;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            acc_q      <= 32'd0;
            mcand_q    <= 32'd0;
            mplier_q   <= 32'd0;
            cnt_q      <= '0;
            rsp_data_q <= 32'd0;
            rsp_ov_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_ov_q   <= rsp_ov_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_ov    = rsp_ov_q;

endmodule
